enigma_uart_tx: RTL and testbench

Output end of the Enigma datapath. Accepts the 5-bit letter-index stream (0=A..25=Z) produced by the cipher core as single-cycle valid pulses and buffers it in a small FIFO. Converts each letter to ASCII and transmits it as UART 8N1 on the board's TX pin. The core has no backpressure, so overflow is detected and flagged, never stalled.

---
 rtl/enigma_pkg.sv | 30 +++
 rtl/enigma_uart_tx_if.sv | 27 ++
 rtl/enigma_char_fifo.sv | 62 ++++++
 rtl/enigma_uart_tx.sv | 188 ++++++++++++++++++
 tb/tb_enigma_uart_tx.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/enigma_pkg.sv
// enigma_pkg: shared types, ASCII constants and the letter-to-ASCII
// translation used by the Enigma UART output stage.
package enigma_pkg;

   localparam int         ALPHABET_SIZE = 26;
   localparam logic [7:0] ASCII_A       = 8'h41;
   localparam logic [7:0] ASCII_SPACE   = 8'h20;
   localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

   typedef logic [4:0] letter_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   // Letter index 0..25 maps to 'A'..'Z'; anything else is sent as '?'.
   function automatic logic [7:0] letter_to_ascii(input letter_t idx);
      logic [7:0] v_byte;
      if ({3'b000, idx} < 8'(ALPHABET_SIZE)) begin
         v_byte = ASCII_A + {3'b000, idx};
      end else begin
         v_byte = ASCII_UNKNOWN;
      end
      return v_byte;
   endfunction

endpackage

// File: rtl/enigma_uart_tx_if.sv
// enigma_uart_tx_if: letter stream in, UART line and status out.
// master = cipher core / test driver side, slave = enigma_uart_tx.
interface enigma_uart_tx_if import enigma_pkg::*; #(
   parameter int FIFO_DEPTH = 16
) ();

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic          valid_in;
   letter_t       char_in;
   logic          clr_overflow;
   logic          tx;
   logic          busy;
   logic [CW-1:0] fifo_count;
   logic          overflow;

   modport master (
      output valid_in, char_in, clr_overflow,
      input  tx, busy, fifo_count, overflow
   );

   modport slave (
      input  valid_in, char_in, clr_overflow,
      output tx, busy, fifo_count, overflow
   );

endinterface

// File: rtl/enigma_char_fifo.sv
// enigma_char_fifo: first-word-fall-through letter FIFO. Push is refused
// when full and pop is refused when empty, both judged on the registered
// count, so a full FIFO never accepts a write even if it pops that cycle.
module enigma_char_fifo import enigma_pkg::*; #(
   parameter  int FIFO_DEPTH = 16,
   localparam int AW = $clog2(FIFO_DEPTH),
   localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  letter_t       i_din,
   input  logic          i_pop,
   output letter_t       o_dout,
   output logic [CW-1:0] o_count,
   output logic          o_full,
   output logic          o_empty
);

   letter_t       r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_count == CW'(FIFO_DEPTH));
   assign o_empty = (r_count == {CW{1'b0}});
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_dout  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   // Storage write; contents need no reset because the count guards reads.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_count  <= {CW{1'b0}};
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/enigma_uart_tx.sv
// enigma_uart_tx: buffers cipher letters, translates them to ASCII and
// sends them as UART 8N1. Define ENIGMA_TX_GROUP_EN to insert a space
// before every sixth letter (classic five-letter groups, no trailing space).
// The line and busy flag are registered from the current FSM state, so the
// serial frame trails the state by one cycle.
module enigma_uart_tx import enigma_pkg::*; #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16
) (
   input logic             clk,
   input logic             rst,
   enigma_uart_tx_if.slave bus
);

   localparam int          CW        = $clog2(FIFO_DEPTH + 1);
   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

   tx_state_t     r_state;
   tx_state_t     w_state_nxt;
   logic [15:0]   r_baud_cnt;
   logic [15:0]   w_baud_nxt;
   logic [2:0]    r_bit_cnt;
   logic [2:0]    w_bit_nxt;
   logic [7:0]    r_shift;
   logic [7:0]    w_shift_nxt;
   logic          r_tx;
   logic          w_tx_nxt;
   logic          r_busy;
   logic          r_overflow;
   letter_t       w_fifo_dout;
   logic [CW-1:0] w_fifo_count;
   logic          w_fifo_full;
   logic          w_fifo_empty;
   logic          w_baud_done;
   logic          w_start;
   logic          w_pop;
   logic          w_load_space;
   logic          w_send_space;

   enigma_char_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (bus.valid_in),
      .i_din   (bus.char_in),
      .i_pop   (w_pop),
      .o_dout  (w_fifo_dout),
      .o_count (w_fifo_count),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   assign w_baud_done = (r_baud_cnt == BAUD_LAST);

`ifdef ENIGMA_TX_GROUP_EN
   logic [2:0] r_grp_cnt;

   assign w_send_space = (r_grp_cnt == 3'd5);

   // Count letters sent since the last space; a space frame restarts the group.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_grp_cnt <= 3'd0;
      end else if (w_load_space) begin
         r_grp_cnt <= 3'd0;
      end else if (w_pop) begin
         r_grp_cnt <= r_grp_cnt + 3'd1;
      end else begin
         r_grp_cnt <= r_grp_cnt;
      end
   end
`else
   assign w_send_space = 1'b0;
`endif

   // Next-state, counters, shift register and next line level.
   always_comb begin
      w_state_nxt  = r_state;
      w_baud_nxt   = r_baud_cnt;
      w_bit_nxt    = r_bit_cnt;
      w_shift_nxt  = r_shift;
      w_tx_nxt     = 1'b1;
      w_start      = 1'b0;
      w_pop        = 1'b0;
      w_load_space = 1'b0;
      case (r_state)
         IDLE: begin
            w_tx_nxt   = 1'b1;
            w_baud_nxt = 16'd0;
            w_bit_nxt  = 3'd0;
            w_start    = ~w_fifo_empty;
         end
         START: begin
            w_tx_nxt = 1'b0;
            if (w_baud_done) begin
               w_baud_nxt  = 16'd0;
               w_bit_nxt   = 3'd0;
               w_state_nxt = DATA;
            end else begin
               w_baud_nxt = r_baud_cnt + 16'd1;
            end
         end
         DATA: begin
            w_tx_nxt = r_shift[0];
            if (w_baud_done) begin
               w_baud_nxt  = 16'd0;
               w_shift_nxt = {1'b0, r_shift[7:1]};
               w_bit_nxt   = r_bit_cnt + 3'd1;
               if (r_bit_cnt == 3'd7) begin
                  w_state_nxt = STOP;
               end else begin
                  w_state_nxt = DATA;
               end
            end else begin
               w_baud_nxt = r_baud_cnt + 16'd1;
            end
         end
         STOP: begin
            w_tx_nxt = 1'b1;
            if (w_baud_done) begin
               w_baud_nxt  = 16'd0;
               w_start     = ~w_fifo_empty;
               w_state_nxt = IDLE;
            end else begin
               w_baud_nxt = r_baud_cnt + 16'd1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_tx_nxt    = 1'b1;
         end
      endcase
      // Frame load: a pending space takes priority and leaves the FIFO alone.
      if (w_start) begin
         w_state_nxt = START;
         w_baud_nxt  = 16'd0;
         w_bit_nxt   = 3'd0;
         if (w_send_space) begin
            w_shift_nxt  = ASCII_SPACE;
            w_load_space = 1'b1;
         end else begin
            w_shift_nxt = letter_to_ascii(w_fifo_dout);
            w_pop       = 1'b1;
         end
      end else begin
         w_pop = 1'b0;
      end
   end

   // FSM state, counters and the registered line/busy outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_baud_cnt <= 16'd0;
         r_bit_cnt  <= 3'd0;
         r_shift    <= 8'h00;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_baud_cnt <= w_baud_nxt;
         r_bit_cnt  <= w_bit_nxt;
         r_shift    <= w_shift_nxt;
         r_tx       <= w_tx_nxt;
         r_busy     <= (r_state != IDLE);
      end
   end

   // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else if (bus.valid_in && w_fifo_full) begin
         r_overflow <= 1'b1;
      end else if (bus.clr_overflow) begin
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= r_overflow;
      end
   end

   assign bus.tx         = r_tx;
   assign bus.busy       = r_busy;
   assign bus.fifo_count = w_fifo_count;
   assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_enigma_uart_tx.sv
// tb_enigma_uart_tx: directed bench for enigma_uart_tx at CLKS_PER_BIT=4,
// FIFO_DEPTH=16. A UART receiver process decodes the line into a byte queue.
module tb_enigma_uart_tx;
   import enigma_pkg::*;

   localparam int CPB   = 4;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   logic [7:0] rx_q[$];
   int         rx_t[$];
   logic [7:0] exp_q[$];

   enigma_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

   enigma_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // UART receiver: find start bit, sample mid-bit, record byte and start cycle.
   initial begin : receiver
      logic [7:0] v_b;
      int         v_t;
      forever begin
         @(negedge clk);
         if (bus.tx === 1'b0) begin
            v_t = cyc;
            repeat (2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               v_b[i] = bus.tx;
            end
            repeat (CPB) @(negedge clk);
            rx_q.push_back(v_b);
            rx_t.push_back(v_t);
            @(negedge clk);
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.valid_in = 1'b0;
      bus.clr_overflow = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      rx_q.delete();
      rx_t.delete();
      exp_q.delete();
   endtask

   task automatic push(input logic [4:0] c);
      bus.valid_in = 1'b1;
      bus.char_in  = c;
      @(negedge clk);
      bus.valid_in = 1'b0;
   endtask

   task automatic wait_rx(input int n);
      for (int k = 0; k < 4000 && rx_q.size() < n; k++) @(negedge clk);
   endtask

   // Expected byte stream for letters first..last, with grouping when enabled.
   task automatic expect_letters(input int first, input int last);
      int grp;
      grp = 0;
      for (int i = first; i <= last; i++) begin
`ifdef ENIGMA_TX_GROUP_EN
         if (grp == 5) begin
            exp_q.push_back(8'h20);
            grp = 0;
         end
`endif
         exp_q.push_back(8'h41 + 8'(i));
         grp++;
      end
   endtask

   task automatic check_stream(input string name);
      total++;
      if (rx_q.size() !== exp_q.size()) begin
         bad++;
         $display("FAIL %s count: got %0d want %0d", name, rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         total++;
         if (rx_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL %s byte%0d: got %h want %h", name, i, rx_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.valid_in = 1'b0;
      bus.clr_overflow = 1'b0;
      bus.char_in = 5'd0;
      repeat (3) @(negedge clk);
      total++; if (bus.tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", bus.tx); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      total++; if (bus.fifo_count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus.fifo_count); end
      total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", bus.overflow); end
      rst = 1'b0;
      @(negedge clk);
      // 'C' = 0x43, bit2 = 0 is on the line 13 negedges after the second push.
      push(5'd2);
      push(5'd3);
      repeat (13) @(negedge clk);
      total++; if (bus.tx !== 1'b0) begin bad++; $display("FAIL mid_data_tx: got %b want 0", bus.tx); end
      total++; if (bus.fifo_count !== 5'd1) begin bad++; $display("FAIL mid_data_count: got %0d want 1", bus.fifo_count); end
      rst = 1'b1;
      @(posedge clk);
      #1;
      total++; if (bus.tx !== 1'b1) begin bad++; $display("FAIL midrst_tx: got %b want 1", bus.tx); end
      total++; if (bus.fifo_count !== 5'd0) begin bad++; $display("FAIL midrst_count: got %0d want 0", bus.fifo_count); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
      @(negedge clk);
      rst = 1'b0;
      repeat (60) @(negedge clk);
   endtask

   task automatic test_single();
      logic [9:0] fr;
      do_reset();
      fr = {1'b1, 8'h48, 1'b0};
      @(negedge clk);
      bus.valid_in = 1'b1;
      bus.char_in  = 5'd7;
      @(posedge clk);
      #1 bus.valid_in = 1'b0;
      @(posedge clk);
      #1;
      total++; if (bus.tx !== 1'b1) begin bad++; $display("FAIL single_early_tx: got %b want 1", bus.tx); end
      @(posedge clk);
      #1;
      for (int k = 0; k < 40; k++) begin
         total++;
         if (bus.tx !== fr[k / CPB]) begin
            bad++;
            $display("FAIL single_frame cyc%0d: got %b want %b", k, bus.tx, fr[k / CPB]);
         end
         total++;
         if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL single_busy cyc%0d: got %b want 1", k, bus.busy);
         end
         @(posedge clk);
         #1;
      end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_end_busy: got %b want 0", bus.busy); end
      total++; if (bus.tx !== 1'b1) begin bad++; $display("FAIL single_end_tx: got %b want 1", bus.tx); end
      wait_rx(1);
      exp_q.push_back(8'h48);
      check_stream("single");
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 18; i++) begin
         bus.valid_in = 1'b1;
         bus.char_in  = 5'(i);
         @(negedge clk);
      end
      bus.valid_in = 1'b0;
      total++; if (bus.fifo_count !== 5'd16) begin bad++; $display("FAIL ovf_count: got %0d want 16", bus.fifo_count); end
      total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", bus.overflow); end
      bus.clr_overflow = 1'b1;
      @(negedge clk);
      bus.clr_overflow = 1'b0;
      total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr: got %b want 0", bus.overflow); end
      bus.clr_overflow = 1'b1;
      bus.valid_in = 1'b1;
      bus.char_in = 5'd20;
      @(negedge clk);
      bus.clr_overflow = 1'b0;
      bus.valid_in = 1'b0;
      total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins: got %b want 1", bus.overflow); end
      total++; if (bus.fifo_count !== 5'd16) begin bad++; $display("FAIL ovf_count2: got %0d want 16", bus.fifo_count); end
      bus.clr_overflow = 1'b1;
      @(negedge clk);
      bus.clr_overflow = 1'b0;
      total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr2: got %b want 0", bus.overflow); end
      expect_letters(0, 16);
      wait_rx(exp_q.size());
      repeat (60) @(negedge clk);
      check_stream("burst");
   endtask

   task automatic test_illegal();
      do_reset();
      push(5'd27);
      push(5'd26);
      push(5'd31);
      exp_q.push_back(8'h3F);
      exp_q.push_back(8'h3F);
      exp_q.push_back(8'h3F);
      wait_rx(3);
      check_stream("illegal");
   endtask

   task automatic test_back_to_back();
      do_reset();
      push(5'd0);
      push(5'd1);
      exp_q.push_back(8'h41);
      exp_q.push_back(8'h42);
      wait_rx(2);
      check_stream("b2b");
      total++;
      if (rx_t.size() < 2) begin
         bad++;
         $display("FAIL b2b_gap: got %0d frames want 2", rx_t.size());
      end else if (rx_t[1] - rx_t[0] !== 10 * CPB) begin
         bad++;
         $display("FAIL b2b_gap: got %0d cycles want %0d", rx_t[1] - rx_t[0], 10 * CPB);
      end
   endtask

   task automatic test_grouping();
      do_reset();
      for (int i = 0; i < 6; i++) push(5'(i));
      expect_letters(0, 5);
      wait_rx(exp_q.size());
      repeat (100) @(negedge clk);
      check_stream("group6");
      do_reset();
      for (int i = 0; i < 5; i++) push(5'(i));
      expect_letters(0, 4);
      wait_rx(exp_q.size());
      repeat (100) @(negedge clk);
      check_stream("group5");
   endtask

   initial begin
      bus.valid_in = 1'b0;
      bus.char_in = 5'd0;
      bus.clr_overflow = 1'b0;
      test_reset();
      test_single();
      test_overflow();
      test_illegal();
      test_back_to_back();
      test_grouping();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
